// File: rtl/noaa_seq_divider.sv
// rtl/noaa_seq_divider.sv - restoring divider, one quotient bit per clock, saturating Q_W-bit AVG_SD
// Optional round-half-up of the final quotient when NOAA_DIV_ROUND_EN is defined.
module noaa_seq_divider #(
  parameter int NUM_W = 33,
  parameter int DEN_W = 22,
  parameter int Q_W   = 12
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [NUM_W-1:0] NUMERATOR,
  input  logic [DEN_W-1:0] DENOMINATOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [Q_W-1:0]   AVG_SD,
  output logic             SAT,
  output logic             DIV_ZERO
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [NUM_W-1:0] num_q;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W:0]   rem_q;
  logic [NUM_W-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DEN_W:0]   rem_shift;
  logic [DEN_W:0]   rem_nxt;
  logic             q_bit;
  logic             round_up;
  logic [NUM_W:0]   quo_ext;
  logic             quo_sat;

  // The remainder is always below den, so its top bit can be dropped before the shift.
  assign rem_shift = {rem_q[DEN_W-1:0], num_q[NUM_W-1]};
  assign q_bit     = (rem_shift >= {1'b0, den_q});
  assign rem_nxt   = q_bit ? (rem_shift - {1'b0, den_q}) : rem_shift;

`ifdef NOAA_DIV_ROUND_EN
  assign round_up = ({rem_q, 1'b0} >= {2'b00, den_q});
`else
  assign round_up = 1'b0;
`endif

  assign quo_ext = {1'b0, quo_q} + {{NUM_W{1'b0}}, round_up};
  assign quo_sat = |quo_ext[NUM_W:Q_W];

  assign BUSY = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt = (DENOMINATOR == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      num_q    <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      DONE     <= 1'b0;
      AVG_SD   <= '0;
      SAT      <= 1'b0;
      DIV_ZERO <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            num_q <= NUMERATOR;
            den_q <= DENOMINATOR;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= CNT_W'(NUM_W);
          end
        end
        S_RUN: begin
          num_q <= {num_q[NUM_W-2:0], 1'b0};
          rem_q <= rem_nxt;
          quo_q <= {quo_q[NUM_W-2:0], q_bit};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        S_FINISH: begin
          DONE <= 1'b1;
          if (den_q == '0) begin
            AVG_SD   <= '1;
            SAT      <= 1'b0;
            DIV_ZERO <= 1'b1;
          end else if (quo_sat) begin
            AVG_SD   <= '1;
            SAT      <= 1'b1;
            DIV_ZERO <= 1'b0;
          end else begin
            AVG_SD   <= quo_ext[Q_W-1:0];
            SAT      <= 1'b0;
            DIV_ZERO <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noaa_seq_divider.sv
// tb/tb_noaa_seq_divider.sv - directed self-checking bench for noaa_seq_divider
module tb_noaa_seq_divider;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [32:0] NUMERATOR;
  logic [21:0] DENOMINATOR;
  logic        BUSY;
  logic        DONE;
  logic [11:0] AVG_SD;
  logic        SAT;
  logic        DIV_ZERO;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int lat;
  int busy_n;
  int mark;

  noaa_seq_divider dut (
    .CLK(CLK),
    .RESET(RESET),
    .START(START),
    .NUMERATOR(NUMERATOR),
    .DENOMINATOR(DENOMINATOR),
    .BUSY(BUSY),
    .DONE(DONE),
    .AVG_SD(AVG_SD),
    .SAT(SAT),
    .DIV_ZERO(DIV_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; START is sampled on the following posedge (E0).
  task automatic pulse_start(input logic [32:0] n, input logic [21:0] d);
    NUMERATOR   = n;
    DENOMINATOR = d;
    START       = 1'b1;
    @(negedge CLK);
    START       = 1'b0;
  endtask

  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (DONE !== 1'b1 && l < 100) begin
      if (BUSY === 1'b1) b++;
      @(negedge CLK);
      l++;
    end
    check("done_timeout", (l < 100) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    RESET       = 1'b0;
    START       = 1'b0;
    NUMERATOR   = '0;
    DENOMINATOR = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_avg", {20'd0, AVG_SD}, 32'd0);
    check("rst_sat", {31'd0, SAT}, 32'd0);
    check("rst_dz", {31'd0, DIV_ZERO}, 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // 1000/10: 34 busy cycles, DONE after edge E0+34
    pulse_start(33'd1000, 22'd10);
    wait_done(lat, busy_n);
    check("n1_latency", lat, 32'd34);
    check("n1_busy_cycles", busy_n, 32'd34);
    check("n1_avg", {20'd0, AVG_SD}, 32'd100);
    check("n1_sat", {31'd0, SAT}, 32'd0);
    check("n1_dz", {31'd0, DIV_ZERO}, 32'd0);
    @(negedge CLK);
    check("n1_done_one_cycle", {31'd0, DONE}, 32'd0);
    check("n1_hold_idle", {20'd0, AVG_SD}, 32'd100);

    // 5/0: divide-by-zero goes straight to FINISH
    pulse_start(33'd5, 22'd0);
    check("dz_hold_busy", {20'd0, AVG_SD}, 32'd100);
    wait_done(lat, busy_n);
    check("dz_latency", lat, 32'd1);
    check("dz_avg", {20'd0, AVG_SD}, 32'd4095);
    check("dz_flag", {31'd0, DIV_ZERO}, 32'd1);
    check("dz_sat", {31'd0, SAT}, 32'd0);
    @(negedge CLK);

    // 2^32 / 1 saturates
    pulse_start(33'h1_0000_0000, 22'd1);
    wait_done(lat, busy_n);
    check("big_avg", {20'd0, AVG_SD}, 32'd4095);
    check("big_sat", {31'd0, SAT}, 32'd1);
    check("big_dz", {31'd0, DIV_ZERO}, 32'd0);
    @(negedge CLK);

    // 7/2: floor 3, rounded 4
    pulse_start(33'd7, 22'd2);
    wait_done(lat, busy_n);
`ifdef NOAA_DIV_ROUND_EN
    check("r72_avg", {20'd0, AVG_SD}, 32'd4);
`else
    check("r72_avg", {20'd0, AVG_SD}, 32'd3);
`endif
    check("r72_sat", {31'd0, SAT}, 32'd0);
    @(negedge CLK);

    // 8191/2 = 4095 r1: the rounding increment reaches 4096 and saturates
    pulse_start(33'd8191, 22'd2);
    wait_done(lat, busy_n);
    check("r8191_avg", {20'd0, AVG_SD}, 32'd4095);
`ifdef NOAA_DIV_ROUND_EN
    check("r8191_sat", {31'd0, SAT}, 32'd1);
`else
    check("r8191_sat", {31'd0, SAT}, 32'd0);
`endif
    @(negedge CLK);

    // Reset mid-division: no DONE, outputs cleared at once
    mark = done_cnt;
    pulse_start(33'd1000, 22'd10);
    repeat (9) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("abort_avg", {20'd0, AVG_SD}, 32'd0);
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (40) @(negedge CLK);
    check("abort_no_done", done_cnt - mark, 32'd0);
    pulse_start(33'd4096, 22'd16);
    wait_done(lat, busy_n);
    check("after_abort_avg", {20'd0, AVG_SD}, 32'd256);
    check("after_abort_latency", lat, 32'd34);
    @(negedge CLK);

    // 300/3 with ignored mid-run START, then back-to-back 50/5 in the DONE cycle
    mark = done_cnt;
    pulse_start(33'd300, 22'd3);
    repeat (5) @(negedge CLK);
    pulse_start(33'd999, 22'd7);
    NUMERATOR   = 33'd12345;
    DENOMINATOR = 22'd99;
    wait_done(lat, busy_n);
    check("b2b_first_avg", {20'd0, AVG_SD}, 32'd100);
    pulse_start(33'd50, 22'd5);
    check("b2b_accepted_busy", {31'd0, BUSY}, 32'd1);
    wait_done(lat, busy_n);
    check("b2b_second_latency", lat, 32'd34);
    check("b2b_second_avg", {20'd0, AVG_SD}, 32'd10);
    repeat (40) @(negedge CLK);
    check("b2b_done_count", done_cnt - mark, 32'd2);
    check("b2b_idle", {31'd0, BUSY}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
